fetch_stage_mo: RTL and testbench
=================================

Name: fetch_stage_mo

Overview:
Next-generation instruction fetch front end with up to OUTSTANDING in-flight bus requests, replacing the single-outstanding fetch stage. It holds a UTLB_ENTRIES-entry fully associative micro-TLB in front of the shared TLB port, and keeps in-order fetch entries for fetches and fetch exceptions. It sits between the PC generator (valid_i/pc_i/ready_o) and decode (valid_o/ready_i), and drives the instruction bus, which has split address/data handshakes and no cancellation.

Parameters:
OUTSTANDING, 4, max allocated fetch entries; power of two, >=2
UTLB_ENTRIES, 4, micro-TLB entries; power of two, >=1

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
valid_i  in  1  PC valid from PC generator
pc_i  in  32  fetch PC
ready_o  out  1  PC accepted this cycle
inst_req  out  1  bus address request
inst_cache  out  1  cacheable request
inst_addr  out  32  physical address
inst_addr_ok  in  1  address accepted
inst_rdata  in  32  read data
inst_data_ok  in  1  read data valid, in request order
tlb_write  in  1  TLB modified; flush micro-TLB
tlb_vaddr  out  32  TLB lookup address, registered
tlb_paddr  in  32  TLB result
tlb_miss  in  1  TLB refill miss
tlb_invalid  in  1  TLB invalid
tlb_cattr  in  3  TLB cache attribute
config_k0  in  3  Config.K0
cancel_i  in  1  flush: kill all younger work
valid_o  out  1  instruction/exception valid to decode
ready_i  in  1  decode accepts
pc_o  out  32  PC of output
inst_o  out  32  instruction word (0 when exc_o)
exc_o  out  1  fetch exception
exc_miss_o  out  1  TLB refill (vs invalid)
exccode_o  out  5  EXC_ADEL or EXC_TLBL
perfcnt_fetch_waitreq  out  32  cycles inst_req=1 && inst_addr_ok=0
perfcnt_fetch_killed  out  32  killed entries discarded

Behaviour:
- Reset: all state and storage cleared asynchronously. Outputs read 0: valid_o, ready_o, inst_req, exc_o, pc_o, inst_o, counters, tlb_vaddr.
- Translation: kseg0/1 (pc[31:30]=2'b10) bypass, paddr={3'b0,pc[28:0]}. Cached iff kseg0 && config_k0[0]; kseg1 is uncached.
- Mapped PCs use the micro-TLB: entry {valid, vpn[19:0], pfn[19:0], miss, invalid, cattr}. Hit = valid && vpn==pc_i[31:12]. Cached iff cattr[0].
- FSM CHECK/QUERY. CHECK: if valid_i and mapped and micro-TLB miss, register pc into tlb_vaddr and go to QUERY. QUERY (1 cycle): fill the entry at the round-robin pointer, including miss/invalid results, advance the pointer, and return to CHECK. The retry then hits.
- CHECK, with valid_i, translation available, no cancel_i and entry free:
  - pc[1:0]!=0: allocate an exception entry, ADEL (priority over TLB). No bus request; ready_o=1.
  - Hit with miss or invalid set: allocate a TLBL exception entry; exc_miss=miss. ready_o=1.
  - Otherwise: inst_req=1. ready_o=inst_addr_ok. On inst_addr_ok, allocate a bus entry.
- Entry FIFO (OUTSTANDING deep): {pc, is_exc, exc_miss, exccode, killed}. Separate response FIFO (OUTSTANDING deep) pushes inst_rdata on inst_data_ok. Responses cannot overflow because bus entries <= OUTSTANDING.
- Full: inst_req=0 and ready_o=0.
- Output is driven from the FIFO heads. valid_o = head valid && !head.killed && (head.is_exc || resp nonempty). Pop on valid_o && ready_i; a bus entry pops head and response together.
- Killed head: an exception entry is popped next cycle unconditionally. A bus entry is popped together with its response when that response arrives. Each such pop increments perfcnt_fetch_killed.
- cancel_i:
  - Sets killed on every allocated entry.
  - Forces FSM to CHECK and invalidates the micro-TLB.
  - Same cycle: inst_req=0, ready_o=0, no allocation.
  - A head pop by decode in the same cycle still completes.
  - inst_data_ok in the same cycle still pushes the response.
- tlb_write invalidates all micro-TLB entries; a QUERY fill in the same cycle is discarded.
- Simultaneous push/pop on either FIFO keeps occupancy unchanged. Pointers wrap modulo OUTSTANDING.

Optional Feature:
FETCH_PERFCNT_EN: defined, both counters count as specified. Undefined, both ports are tied to 32'd0 and no counter registers exist.

Decomposition:
- Shared package/header: EXC_ADEL (5'd4), EXC_TLBL (5'd2), FSM state encodings, micro-TLB entry field widths.
- Natural sub-module: fetch_utlb (micro-TLB storage, lookup, round-robin fill, flush).

Test Plan:
1. Reset, then valid_i=1 with pc_i=0xBFC00000 and addr_ok immediate; data_ok with latency 3, 4 PCs back-to-back -> 4 requests accepted without waiting for data; inst_addr=0x1FC00000, 0x1FC00004, and so on; inst_cache=0; outputs in order.
2. OUTSTANDING=4 with data withheld -> 4 allocations, then inst_req=0 and ready_o=0; one data_ok plus ready_i -> exactly one new request.
3. pc_i=0x00400000, micro-TLB empty, tlb_paddr=0x01234000, tlb_cattr=3 -> QUERY 1 cycle; request inst_addr=0x01234000, inst_cache=1; next PC 0x00400004 issues with no query.
4. pc_i=0x80000002 -> exc_o=1, exccode_o=4, no inst_req. Mapped PC with tlb_miss=1 -> exccode_o=2, exc_miss_o=1.
5. 3 requests outstanding, cancel_i pulse -> 3 late data_ok consumed with no valid_o; perfcnt_fetch_killed=3; a new PC is then fetched normally.
6. tlb_write during a hit stream -> next mapped PC re-queries (QUERY visible); cancel_i in the same cycle as data_ok -> no loss or duplication.

Source files
------------

// File: rtl/fetch_stage_mo_pkg.sv
// Shared definitions for the multi-outstanding fetch stage: exception codes,
// FSM state encodings, micro-TLB field widths and the entry record layouts.
package fetch_stage_mo_pkg;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_TLBL = 5'd2;

    localparam logic [0:0] ST_CHECK = 1'b0;
    localparam logic [0:0] ST_QUERY = 1'b1;

    localparam int unsigned VPN_W   = 20;
    localparam int unsigned PFN_W   = 20;
    localparam int unsigned CATTR_W = 3;

    typedef struct packed {
        logic               valid;
        logic [VPN_W-1:0]   vpn;
        logic [PFN_W-1:0]   pfn;
        logic               miss;
        logic               invalid;
        logic [CATTR_W-1:0] cattr;
    } utlb_entry_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        is_exc;
        logic        exc_miss;
        logic [4:0]  exccode;
        logic        killed;
    } fetch_entry_t;

    // kseg0/kseg1 bypass translation entirely
    function automatic logic is_unmapped(input logic [31:0] va);
        return va[31:30] == 2'b10;
    endfunction

endpackage

// File: rtl/fetch_stage_mo_utlb.sv
// Fully associative micro-TLB: parallel lookup, round-robin fill, whole flush.
// Refill-miss and invalid results are cached too, so a faulting PC does not
// re-query the shared TLB on every retry.
module fetch_utlb
    import fetch_stage_mo_pkg::*;
#(
    parameter int unsigned UTLB_ENTRIES = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [VPN_W-1:0]   lookup_vpn_i,
    output logic               hit_o,
    output logic [PFN_W-1:0]   pfn_o,
    output logic               miss_o,
    output logic               invalid_o,
    output logic [CATTR_W-1:0] cattr_o,
    input  logic               fill_i,
    input  logic [VPN_W-1:0]   fill_vpn_i,
    input  logic [PFN_W-1:0]   fill_pfn_i,
    input  logic               fill_miss_i,
    input  logic               fill_invalid_i,
    input  logic [CATTR_W-1:0] fill_cattr_i,
    input  logic               flush_i
);

    localparam int unsigned RR_W = (UTLB_ENTRIES > 1) ? $clog2(UTLB_ENTRIES) : 1;

    utlb_entry_t       tlb_q [UTLB_ENTRIES];
    logic [RR_W-1:0]   rr_q, rr_d;
    logic              fill_we;
    utlb_entry_t       fill_ent;

    // a flush in the same cycle discards the fill
    assign fill_we = fill_i && !flush_i;

    // assemble the entry being written
    always_comb begin
        fill_ent         = '0;
        fill_ent.valid   = 1'b1;
        fill_ent.vpn     = fill_vpn_i;
        fill_ent.pfn     = fill_pfn_i;
        fill_ent.miss    = fill_miss_i;
        fill_ent.invalid = fill_invalid_i;
        fill_ent.cattr   = fill_cattr_i;
    end

    // parallel tag compare; first matching entry wins
    always_comb begin
        hit_o     = 1'b0;
        pfn_o     = '0;
        miss_o    = 1'b0;
        invalid_o = 1'b0;
        cattr_o   = '0;
        for (int unsigned i = 0; i < UTLB_ENTRIES; i++) begin
            if (!hit_o && tlb_q[i].valid && tlb_q[i].vpn == lookup_vpn_i) begin
                hit_o     = 1'b1;
                pfn_o     = tlb_q[i].pfn;
                miss_o    = tlb_q[i].miss;
                invalid_o = tlb_q[i].invalid;
                cattr_o   = tlb_q[i].cattr;
            end
        end
    end

    // round-robin victim pointer advances on every accepted fill
    always_comb begin
        rr_d = rr_q;
        if (fill_we) begin
            rr_d = (rr_q == RR_W'(UTLB_ENTRIES - 1)) ? '0 : rr_q + 1'b1;
        end
    end

    // entry storage: flush clears valid bits, otherwise write the victim slot
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < UTLB_ENTRIES; i++) tlb_q[i] <= '0;
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
            for (int unsigned i = 0; i < UTLB_ENTRIES; i++) begin
                if (flush_i) begin
                    tlb_q[i].valid <= 1'b0;
                end else if (fill_we && rr_q == RR_W'(i)) begin
                    tlb_q[i] <= fill_ent;
                end
            end
        end
    end

endmodule

// File: rtl/fetch_stage_mo.sv
// Instruction fetch front end with up to OUTSTANDING in-flight bus requests.
// Micro-TLB in front of the shared TLB port, in-order entry FIFO plus a
// separate response FIFO. Optional macro FETCH_PERFCNT_EN enables the two
// performance counters; without it both counter ports read zero.
module fetch_stage_mo
    import fetch_stage_mo_pkg::*;
#(
    parameter int unsigned OUTSTANDING  = 4,
    parameter int unsigned UTLB_ENTRIES = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    output logic        ready_o,
    output logic        inst_req,
    output logic        inst_cache,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic [31:0] inst_rdata,
    input  logic        inst_data_ok,
    input  logic        tlb_write,
    output logic [31:0] tlb_vaddr,
    input  logic [31:0] tlb_paddr,
    input  logic        tlb_miss,
    input  logic        tlb_invalid,
    input  logic [2:0]  tlb_cattr,
    input  logic [2:0]  config_k0,
    input  logic        cancel_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        exc_o,
    output logic        exc_miss_o,
    output logic [4:0]  exccode_o,
    output logic [31:0] perfcnt_fetch_waitreq,
    output logic [31:0] perfcnt_fetch_killed
);

    localparam int unsigned PTR_W = $clog2(OUTSTANDING);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [0:0]         state_q, state_d;
    logic [31:0]        tlb_vaddr_q, tlb_vaddr_d;
    logic               utlb_fill;

    logic               u_hit;
    logic [PFN_W-1:0]   u_pfn;
    logic               u_miss;
    logic               u_invalid;
    logic [CATTR_W-1:0] u_cattr;

    logic               unmapped;
    logic               trans_ok;
    logic [31:0]        paddr;
    logic               cached;
    logic               misalign;
    logic               tlb_exc;
    logic               can_go;
    logic               alloc;
    fetch_entry_t       new_ent;

    fetch_entry_t       ent_q [OUTSTANDING];
    logic [PTR_W-1:0]   e_wptr_q, e_wptr_d, e_rptr_q, e_rptr_d;
    logic [CNT_W-1:0]   e_cnt_q, e_cnt_d;
    logic [31:0]        resp_q [OUTSTANDING];
    logic [PTR_W-1:0]   r_wptr_q, r_wptr_d, r_rptr_q, r_rptr_d;
    logic [CNT_W-1:0]   r_cnt_q, r_cnt_d;

    fetch_entry_t       head;
    logic               ent_nonempty;
    logic               resp_nonempty;
    logic               ent_full;
    logic               head_ready;
    logic               pop_out;
    logic               kill_pop;
    logic               ent_pop;
    logic               resp_pop;

    logic               unused_sigs;
    assign unused_sigs = ^{tlb_paddr[11:0], config_k0[2:1], u_cattr[CATTR_W-1:1]};

    fetch_utlb #(
        .UTLB_ENTRIES (UTLB_ENTRIES)
    ) u_utlb (
        .clk            (clk),
        .resetn         (resetn),
        .lookup_vpn_i   (pc_i[31:12]),
        .hit_o          (u_hit),
        .pfn_o          (u_pfn),
        .miss_o         (u_miss),
        .invalid_o      (u_invalid),
        .cattr_o        (u_cattr),
        .fill_i         (utlb_fill),
        .fill_vpn_i     (tlb_vaddr_q[31:12]),
        .fill_pfn_i     (tlb_paddr[31:12]),
        .fill_miss_i    (tlb_miss),
        .fill_invalid_i (tlb_invalid),
        .fill_cattr_i   (tlb_cattr),
        .flush_i        (tlb_write || cancel_i)
    );

    // address translation: segment bypass or micro-TLB result
    always_comb begin
        unmapped = is_unmapped(pc_i);
        if (unmapped) begin
            paddr  = {3'b000, pc_i[28:0]};
            cached = !pc_i[29] && config_k0[0];
        end else begin
            paddr  = {u_pfn, pc_i[11:0]};
            cached = u_cattr[0];
        end
        trans_ok = unmapped || u_hit;
    end

    // CHECK/QUERY sequencing for micro-TLB refills from the shared TLB
    always_comb begin
        state_d     = state_q;
        tlb_vaddr_d = tlb_vaddr_q;
        utlb_fill   = 1'b0;
        if (cancel_i) begin
            state_d = ST_CHECK;
        end else if (state_q == ST_CHECK) begin
            if (valid_i && !unmapped && !u_hit) begin
                state_d     = ST_QUERY;
                tlb_vaddr_d = pc_i;
            end
        end else begin
            utlb_fill = 1'b1;
            state_d   = ST_CHECK;
        end
    end

    // FSM and lookup-address registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_CHECK;
            tlb_vaddr_q <= '0;
        end else begin
            state_q     <= state_d;
            tlb_vaddr_q <= tlb_vaddr_d;
        end
    end

    assign tlb_vaddr = tlb_vaddr_q;

    // request/allocate decision; misalignment outranks TLB faults
    assign ent_full   = (e_cnt_q == CNT_W'(OUTSTANDING));
    assign misalign   = (pc_i[1:0] != 2'b00);
    assign tlb_exc    = !unmapped && (u_miss || u_invalid);
    assign can_go     = (state_q == ST_CHECK) && valid_i && trans_ok && !cancel_i && !ent_full;
    assign inst_req   = can_go && !misalign && !tlb_exc;
    assign inst_addr  = paddr;
    assign inst_cache = cached;
    assign ready_o    = (can_go && (misalign || tlb_exc)) || (inst_req && inst_addr_ok);
    assign alloc      = ready_o;

    // record written into the entry FIFO on allocation
    always_comb begin
        new_ent    = '0;
        new_ent.pc = pc_i;
        if (misalign) begin
            new_ent.is_exc  = 1'b1;
            new_ent.exccode = EXC_ADEL;
        end else if (tlb_exc) begin
            new_ent.is_exc   = 1'b1;
            new_ent.exc_miss = u_miss;
            new_ent.exccode  = EXC_TLBL;
        end
    end

    // head-of-queue control: deliver live entries, silently retire killed ones
    assign head          = ent_q[e_rptr_q];
    assign ent_nonempty  = (e_cnt_q != '0);
    assign resp_nonempty = (r_cnt_q != '0);
    assign head_ready    = ent_nonempty && (head.is_exc || resp_nonempty);
    assign valid_o       = head_ready && !head.killed;
    assign pop_out       = valid_o && ready_i;
    assign kill_pop      = head_ready && head.killed;
    assign ent_pop       = pop_out || kill_pop;
    assign resp_pop      = ent_pop && !head.is_exc;

    assign pc_o       = valid_o ? head.pc : '0;
    assign exc_o      = valid_o && head.is_exc;
    assign exc_miss_o = valid_o && head.is_exc && head.exc_miss;
    assign exccode_o  = (valid_o && head.is_exc) ? head.exccode : '0;
    assign inst_o     = (valid_o && !head.is_exc) ? resp_q[r_rptr_q] : '0;

    // pointer and occupancy update for both FIFOs
    always_comb begin
        e_wptr_d = e_wptr_q + PTR_W'(alloc);
        e_rptr_d = e_rptr_q + PTR_W'(ent_pop);
        e_cnt_d  = e_cnt_q + CNT_W'(alloc) - CNT_W'(ent_pop);
        r_wptr_d = r_wptr_q + PTR_W'(inst_data_ok);
        r_rptr_d = r_rptr_q + PTR_W'(resp_pop);
        r_cnt_d  = r_cnt_q + CNT_W'(inst_data_ok) - CNT_W'(resp_pop);
    end

    // entry FIFO storage; cancel marks every slot killed (no alloc that cycle)
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < OUTSTANDING; i++) ent_q[i] <= '0;
            e_wptr_q <= '0;
            e_rptr_q <= '0;
            e_cnt_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < OUTSTANDING; i++) begin
                if (cancel_i) ent_q[i].killed <= 1'b1;
            end
            if (alloc) ent_q[e_wptr_q] <= new_ent;
            e_wptr_q <= e_wptr_d;
            e_rptr_q <= e_rptr_d;
            e_cnt_q  <= e_cnt_d;
        end
    end

    // response FIFO storage, filled in bus order
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < OUTSTANDING; i++) resp_q[i] <= '0;
            r_wptr_q <= '0;
            r_rptr_q <= '0;
            r_cnt_q  <= '0;
        end else begin
            if (inst_data_ok) resp_q[r_wptr_q] <= inst_rdata;
            r_wptr_q <= r_wptr_d;
            r_rptr_q <= r_rptr_d;
            r_cnt_q  <= r_cnt_d;
        end
    end

`ifdef FETCH_PERFCNT_EN
    logic [31:0] waitreq_cnt_q;
    logic [31:0] killed_cnt_q;

    // stall cycles on the address channel and discarded entries
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            waitreq_cnt_q <= '0;
            killed_cnt_q  <= '0;
        end else begin
            if (inst_req && !inst_addr_ok) waitreq_cnt_q <= waitreq_cnt_q + 32'd1;
            if (kill_pop) killed_cnt_q <= killed_cnt_q + 32'd1;
        end
    end

    assign perfcnt_fetch_waitreq = waitreq_cnt_q;
    assign perfcnt_fetch_killed  = killed_cnt_q;
`else
    assign perfcnt_fetch_waitreq = 32'd0;
    assign perfcnt_fetch_killed  = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage_mo.sv
// Directed bench for fetch_stage_mo: in-order bus model with fixed data
// latency, simple TLB responder, expected-output scoreboard queue.
module tb_fetch_stage_mo;

    localparam logic [19:0] PFN_OFF = 20'h00E34;
    localparam int unsigned LAT     = 3;
`ifdef FETCH_PERFCNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        valid_i;
    logic [31:0] pc_i;
    logic        ready_o;
    logic        inst_req;
    logic        inst_cache;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic [31:0] inst_rdata;
    logic        inst_data_ok;
    logic        tlb_write;
    logic [31:0] tlb_vaddr;
    logic [31:0] tlb_paddr;
    logic        tlb_miss;
    logic        tlb_invalid;
    logic [2:0]  tlb_cattr;
    logic [2:0]  config_k0;
    logic        cancel_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        exc_o;
    logic        exc_miss_o;
    logic [4:0]  exccode_o;
    logic [31:0] perfcnt_fetch_waitreq;
    logic [31:0] perfcnt_fetch_killed;

    fetch_stage_mo #(
        .OUTSTANDING  (4),
        .UTLB_ENTRIES (4)
    ) dut (
        .clk                   (clk),
        .resetn                (resetn),
        .valid_i               (valid_i),
        .pc_i                  (pc_i),
        .ready_o               (ready_o),
        .inst_req              (inst_req),
        .inst_cache            (inst_cache),
        .inst_addr             (inst_addr),
        .inst_addr_ok          (inst_addr_ok),
        .inst_rdata            (inst_rdata),
        .inst_data_ok          (inst_data_ok),
        .tlb_write             (tlb_write),
        .tlb_vaddr             (tlb_vaddr),
        .tlb_paddr             (tlb_paddr),
        .tlb_miss              (tlb_miss),
        .tlb_invalid           (tlb_invalid),
        .tlb_cattr             (tlb_cattr),
        .config_k0             (config_k0),
        .cancel_i              (cancel_i),
        .valid_o               (valid_o),
        .ready_i               (ready_i),
        .pc_o                  (pc_o),
        .inst_o                (inst_o),
        .exc_o                 (exc_o),
        .exc_miss_o            (exc_miss_o),
        .exccode_o             (exccode_o),
        .perfcnt_fetch_waitreq (perfcnt_fetch_waitreq),
        .perfcnt_fetch_killed  (perfcnt_fetch_killed)
    );

    always #5 clk = ~clk;

    // shared TLB: fixed page offset applied to the registered lookup address
    assign tlb_paddr = {tlb_vaddr[31:12] + PFN_OFF, 12'h000};

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        is_exc;
        logic        miss;
        logic [4:0]  code;
        logic [31:0] paddr;
        logic        cache;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] bus_addr_q [$];
    int unsigned bus_due_q [$];
    int unsigned cyc = 0;
    int unsigned req_cnt = 0;
    int unsigned out_cnt = 0;
    bit          data_hold = 1'b0;
    bit          data_one  = 1'b0;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // reference translation and fault classification for one PC
    function automatic exp_t model(input logic [31:0] pc);
        exp_t m;
        logic um;
        um      = (pc[31:30] == 2'b10);
        m.pc    = pc;
        m.paddr = um ? {3'b000, pc[28:0]} : {pc[31:12] + PFN_OFF, pc[11:0]};
        m.cache = um ? (!pc[29] && config_k0[0]) : tlb_cattr[0];
        m.is_exc = 1'b0; m.miss = 1'b0; m.code = 5'd0; m.inst = 32'd0;
        if (pc[1:0] != 2'b00) begin
            m.is_exc = 1'b1; m.code = 5'd4;
        end else if (!um && (tlb_miss || tlb_invalid)) begin
            m.is_exc = 1'b1; m.code = 5'd2; m.miss = tlb_miss;
        end else begin
            m.inst = mem_word(m.paddr);
        end
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // bus address capture
    always @(negedge clk) begin
        if (resetn && inst_req && inst_addr_ok) begin
            bus_addr_q.push_back(inst_addr);
            bus_due_q.push_back(cyc + LAT);
            req_cnt++;
        end
    end

    // in-order data return, one beat per cycle, optionally withheld
    initial begin : responder
        inst_data_ok = 1'b0;
        inst_rdata   = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            inst_data_ok = 1'b0;
            inst_rdata   = '0;
            if (resetn && bus_addr_q.size() > 0 && bus_due_q[0] <= cyc && (!data_hold || data_one)) begin
                inst_data_ok = 1'b1;
                inst_rdata   = mem_word(bus_addr_q.pop_front());
                void'(bus_due_q.pop_front());
                data_one = 1'b0;
            end
        end
    end

    // output monitor: pop scoreboard on every decode handshake
    always @(negedge clk) begin
        if (resetn) begin
            if (valid_o && ready_i) begin
                out_cnt++;
                checks++;
                assert (exp_q.size() > 0) else begin
                    errors++;
                    $error("FAIL spurious_out observed pc=%h expected no output", pc_o);
                end
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_pc", pc_o, e.pc);
                    chk("out_inst", inst_o, e.inst);
                    chk("out_exc", 32'(exc_o), 32'(e.is_exc));
                    chk("out_exc_miss", 32'(exc_miss_o), 32'(e.miss));
                    chk("out_exccode", 32'(exccode_o), 32'(e.code));
                end
            end
            if (cancel_i) exp_q.delete();
        end
    end

    // present one PC until accepted; exp_wait < 0 means any wait is allowed
    task automatic send_pc(input logic [31:0] pc, input int exp_wait);
        exp_t m;
        int   w;
        bit   ok;
        m = model(pc);
        valid_i = 1'b1;
        pc_i    = pc;
        w  = 0;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (exp_wait == 2 && w == 1) chk("tlb_vaddr_query", tlb_vaddr, pc);
            if (ready_o) ok = 1'b1;
            else begin
                @(posedge clk); #1;
                w++;
            end
        end
        if (ok) begin
            if (exp_wait >= 0) chk("accept_wait", 32'(w), 32'(exp_wait));
            if (m.is_exc) begin
                chk("exc_no_req", 32'(inst_req), 32'd0);
            end else begin
                chk("req", 32'(inst_req), 32'd1);
                chk("req_addr", inst_addr, m.paddr);
                chk("req_cache", 32'(inst_cache), 32'(m.cache));
            end
            exp_q.push_back(m);
        end else begin
            chk("send_timeout", 32'(ok), 32'd1);
        end
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && bus_addr_q.size() == 0) ok = 1'b1;
        end
        chk("drain", 32'(ok), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        int unsigned base;
        resetn = 1'b0; valid_i = 1'b0; pc_i = '0; inst_addr_ok = 1'b1;
        tlb_write = 1'b0; tlb_miss = 1'b0; tlb_invalid = 1'b0; tlb_cattr = 3'd3;
        config_k0 = 3'd3; cancel_i = 1'b0; ready_i = 1'b1;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_valid_o", 32'(valid_o), 32'd0);
        chk("rst_ready_o", 32'(ready_o), 32'd0);
        chk("rst_inst_req", 32'(inst_req), 32'd0);
        chk("rst_exc_o", 32'(exc_o), 32'd0);
        chk("rst_pc_o", pc_o, 32'd0);
        chk("rst_inst_o", inst_o, 32'd0);
        chk("rst_tlb_vaddr", tlb_vaddr, 32'd0);
        chk("rst_waitreq", perfcnt_fetch_waitreq, 32'd0);
        chk("rst_killed", perfcnt_fetch_killed, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        step(1);

        // 1: kseg1 stream, four requests without waiting for data
        for (int i = 0; i < 4; i++) send_pc(32'hBFC0_0000 + 32'(4 * i), 0);
        drain();

        // 2: fill all entries with data withheld, then release one response
        data_hold = 1'b1;
        for (int i = 0; i < 4; i++) send_pc(32'hBFC0_0010 + 32'(4 * i), 0);
        valid_i = 1'b1; pc_i = 32'hBFC0_0020;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("full_no_req", 32'(inst_req), 32'd0);
            chk("full_not_ready", 32'(ready_o), 32'd0);
            @(posedge clk); #1;
        end
        base = req_cnt;
        data_one = 1'b1;
        send_pc(32'hBFC0_0020, -1);
        step(6);
        chk("one_slot_one_req", 32'(req_cnt), 32'(base + 1));
        data_hold = 1'b0;
        drain();

        // 3: mapped PC, micro-TLB refill then hit
        send_pc(32'h0040_0000, 2);
        send_pc(32'h0040_0004, 0);
        drain();

        // 4: address error and TLB faults
        send_pc(32'h8000_0002, 0);
        tlb_miss = 1'b1;
        send_pc(32'h0080_0000, 2);
        tlb_miss = 1'b0; tlb_invalid = 1'b1;
        send_pc(32'h0090_0000, 2);
        tlb_invalid = 1'b0;
        drain();

        // 5: cancel with three requests in flight
        data_hold = 1'b1;
        for (int i = 0; i < 3; i++) send_pc(32'h8000_0100 + 32'(4 * i), 0);
        step(2);
        cancel_i = 1'b1; valid_i = 1'b1; pc_i = 32'hBFC0_0500;
        @(negedge clk);
        chk("cancel_no_req", 32'(inst_req), 32'd0);
        chk("cancel_not_ready", 32'(ready_o), 32'd0);
        @(posedge clk); #1;
        cancel_i = 1'b0; valid_i = 1'b0; data_hold = 1'b0;
        base = out_cnt;
        step(10);
        chk("killed_no_output", 32'(out_cnt), 32'(base));
        chk("killed_valid_o", 32'(valid_o), 32'd0);
        chk("perf_killed_3", perfcnt_fetch_killed, PERF ? 32'd3 : 32'd0);
        send_pc(32'hBFC0_0100, 0);
        drain();

        // 6a: tlb_write during a hit stream forces a re-query
        send_pc(32'h0040_0010, 2);
        tlb_write = 1'b1;
        send_pc(32'h0040_0014, 0);
        tlb_write = 1'b0;
        send_pc(32'h0040_0018, 2);
        drain();

        // 6b: cancel in the same cycle as a data return
        data_hold = 1'b1;
        send_pc(32'hBFC0_0200, 0);
        send_pc(32'hBFC0_0204, 0);
        step(4);
        data_hold = 1'b0; cancel_i = 1'b1;
        step(1);
        cancel_i = 1'b0;
        base = out_cnt;
        step(8);
        chk("cancel_data_no_output", 32'(out_cnt), 32'(base));
        chk("perf_killed_5", perfcnt_fetch_killed, PERF ? 32'd5 : 32'd0);
        send_pc(32'hBFC0_0300, 0);
        drain();

        // 6c: address-channel stall
        inst_addr_ok = 1'b0; valid_i = 1'b1; pc_i = 32'hBFC0_0400;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_req", 32'(inst_req), 32'd1);
            chk("stall_not_ready", 32'(ready_o), 32'd0);
            @(posedge clk); #1;
        end
        inst_addr_ok = 1'b1;
        send_pc(32'hBFC0_0400, 0);
        drain();
        @(negedge clk);
        chk("idle_valid_o", 32'(valid_o), 32'd0);
        chk("perf_waitreq", perfcnt_fetch_waitreq, PERF ? 32'd3 : 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
